// File: rtl/fpadd_seq_driver.sv
// ---------------------------------------------------------------------------
// fpadd_seq_driver
//
// Initiator for the FPADD half-precision adder's serial operand protocol.
// It accepts an operand pair {A,B} on a valid/ready input and sends it to the
// adder over two cycles: a St strobe with A on FPinput, then B on FPinput.
// It then waits for the adder's done flag, captures FPsum/ovf/unf and presents
// them on a valid/ready result output. Only one operation is in flight.
//
// Optional feature (compile-time macro FPDRV_TIMEOUT_EN):
//   When defined, a WAIT watchdog aborts after TIMEOUT_CYCLES cycles without
//   done and returns a quiet-NaN result (16'h7E00) flagged with res_tmo=1.
//   When undefined, WAIT holds until done and res_tmo is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles before abort (timeout build only)
//   TO_W            timeout counter width, 2**TO_W > TIMEOUT_CYCLES
//
// Ports:
//   CLK, RST_N                  clock, asynchronous active-low reset
//   op_valid/op_ready           operand handshake
//   op_a, op_b                  operands (A is sent first)
//   St, FPinput                 start strobe and operand bus to FPADD
//   done, ovf, unf, FPsum       FPADD status and result
//   res_valid/res_ready         result handshake
//   res_sum, res_ovf, res_unf   captured adder result
//   res_tmo                     result is a timeout abort
//   busy                        high in every state except IDLE
//
// FPADD itself has no reset: RST_N must be held low for at least 64 CLK so
// the adder has drained back to its idle state before new traffic.
// ---------------------------------------------------------------------------
module fpadd_seq_driver #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        St,
    output logic [15:0] FPinput,
    input  logic        done,
    input  logic        ovf,
    input  logic        unf,
    input  logic [15:0] FPsum,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_sum,
    output logic        res_ovf,
    output logic        res_unf,
    output logic        res_tmo,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    logic [15:0] b_lat;

    // Elaboration-time guard: the watchdog counter must be able to reach
    // TIMEOUT_CYCLES-1 without wrapping.
    generate
        if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
            $error("fpadd_seq_driver: TO_W too narrow for TIMEOUT_CYCLES");
        end
    endgenerate

`ifdef FPDRV_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign res_tmo = 1'b0;
`endif

    // In HOLD res_valid is always set, so the result handshake reduces to
    // res_ready and a new pair can be taken in that same cycle.
    assign op_ready = (state == IDLE) || ((state == HOLD) && res_ready);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            b_lat     <= '0;
            St        <= 1'b0;
            FPinput   <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_ovf   <= 1'b0;
            res_unf   <= 1'b0;
            busy      <= 1'b0;
`ifdef FPDRV_TIMEOUT_EN
            res_tmo   <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        b_lat   <= op_b;
                        FPinput <= op_a;
                        St      <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SEND_A;
                    end
                end

                // FPADD samples A (and clears its done) on the edge ending this state.
                SEND_A: begin
                    St      <= 1'b0;
                    FPinput <= b_lat;
                    state   <= SEND_B;
                end

                SEND_B: begin
`ifdef FPDRV_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state  <= WAIT;
                end

                // done is only looked at here, so a stale done left over in
                // IDLE/HOLD from an earlier operation has no effect.
                WAIT: begin
                    if (done) begin
                        res_sum   <= FPsum;
                        res_ovf   <= ovf;
                        res_unf   <= unf;
                        res_valid <= 1'b1;
`ifdef FPDRV_TIMEOUT_EN
                        res_tmo   <= 1'b0;
`endif
                        state     <= HOLD;
                    end
`ifdef FPDRV_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        res_sum   <= 16'h7E00;
                        res_ovf   <= 1'b0;
                        res_unf   <= 1'b0;
                        res_tmo   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (op_valid) begin
                            // Back-to-back: skip IDLE and start the next pair now.
                            b_lat   <= op_b;
                            FPinput <= op_a;
                            St      <= 1'b1;
                            state   <= SEND_A;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    St    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_seq_driver.sv
// ---------------------------------------------------------------------------
// tb_fpadd_seq_driver
//
// Self-checking bench for fpadd_seq_driver. A behavioural FPADD model samples
// A and B from the serial bus and raises done a chosen number of cycles later.
// Operands are integers in [-1000,1000], exactly representable in IEEE half,
// so the expected sum is the integer sum re-encoded as a half.
// A negedge monitor tracks transactions (accepted op, result handshake) and
// derives the expected St, FPinput, busy, op_ready, latency and result.
// ---------------------------------------------------------------------------
module tb_fpadd_seq_driver;

    localparam int TMO = 64;

    logic        CLK;
    logic        RST_N;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        St;
    logic [15:0] FPinput;
    logic        done;
    logic        ovf;
    logic        unf;
    logic [15:0] FPsum;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_sum;
    logic        res_ovf;
    logic        res_unf;
    logic        res_tmo;
    logic        busy;

    fpadd_seq_driver #(
        .TIMEOUT_CYCLES(TMO),
        .TO_W          (7)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .St       (St),
        .FPinput  (FPinput),
        .done     (done),
        .ovf      (ovf),
        .unf      (unf),
        .FPsum    (FPsum),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum  (res_sum),
        .res_ovf  (res_ovf),
        .res_unf  (res_unf),
        .res_tmo  (res_tmo),
        .busy     (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ------------------------------------------------------------------
    // Counters and checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Half-precision helpers for integers with |n| < 2048
    // ------------------------------------------------------------------
    function automatic logic [15:0] int_to_half(input int n);
        int m;
        int e;
        logic [15:0] h;
        if (n == 0) return 16'h0000;
        m = (n < 0) ? -n : n;
        e = 0;
        for (int k = 0; k < 11; k++) if (m >= (1 << k)) e = k;
        h[15]    = (n < 0);
        h[14:10] = 5'(e + 15);
        h[9:0]   = 10'((m << (10 - e)) & 32'h3FF);
        return h;
    endfunction

    function automatic int half_to_int(input logic [15:0] h);
        int e;
        int m;
        if (h[14:0] == 15'd0) return 0;
        e = int'(h[14:10]) - 15;
        if (e < 0 || e > 10) return 0;
        m = (1024 + int'(h[9:0])) >> (10 - e);
        return h[15] ? -m : m;
    endfunction

    // ------------------------------------------------------------------
    // Transaction records
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        ovf;
        logic        unf;
        logic        tmo;
        int          lat;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        int   lat;
        logic ovf;
        logic unf;
    } ad_t;

    ad_t adder_q[$];

    // Attributes of the operation currently being offered on op_valid.
    logic [15:0] nx_sum;
    logic        nx_ovf;
    logic        nx_unf;
    logic        nx_tmo;
    int          nx_lat_ad;
    int          nx_lat_exp;

    int          accepted = 0;
    int          results  = 0;
    int          aborted  = 0;
    int          b2b      = 0;
    logic [15:0] last_sum = '0;
    logic        last_tmo = 1'b0;

    // ------------------------------------------------------------------
    // Behavioural FPADD: samples A with St, B on the following edge, then
    // raises done 'lat' edges after sampling B. done stays high (stale) until
    // the next St. FPsum carries junk while the addition is in progress.
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] a_s;
        logic [15:0] b_s;
        int          ph;
        int          cnt;
        ad_t         cur_ad;
        done  = 1'b0;
        ovf   = 1'b0;
        unf   = 1'b0;
        FPsum = '0;
        ph    = 0;
        cnt   = 0;
        a_s   = '0;
        b_s   = '0;
        cur_ad = '{lat: 1, ovf: 1'b0, unf: 1'b0};
        forever begin
            @(posedge CLK);
            if (St) begin
                a_s  = FPinput;
                done <= 1'b0;
                if (adder_q.size() > 0) cur_ad = adder_q.pop_front();
                else cur_ad = '{lat: 1, ovf: 1'b0, unf: 1'b0};
                FPsum <= 16'($urandom);
                ph = 1;
            end else if (ph == 1) begin
                b_s = FPinput;
                cnt = cur_ad.lat;
                ph  = 2;
            end else if (ph == 2) begin
                if (cnt <= 1) begin
                    done  <= 1'b1;
                    FPsum <= int_to_half(half_to_int(a_s) + half_to_int(b_s));
                    ovf   <= cur_ad.ovf;
                    unf   <= cur_ad.unf;
                    ph = 0;
                end else begin
                    cnt--;
                    FPsum <= 16'($urandom);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Consumer: res_ready policy (0 = always ready, 1 = random, 2 = stalled)
    // ------------------------------------------------------------------
    int rr_mode = 0;

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard, evaluated on the falling edge
    // ------------------------------------------------------------------
    initial begin
        exp_t        cur;
        int          cyc;
        bit          in_flight;
        bit          st_due;
        bit          b_due;
        bit          prev_valid;
        bit          prev_stall;
        logic [15:0] prev_sum;
        logic [2:0]  prev_flags;
        cyc        = 0;
        in_flight  = 0;
        st_due     = 0;
        b_due      = 0;
        prev_valid = 0;
        prev_stall = 0;
        prev_sum   = '0;
        prev_flags = '0;
        cur        = '{a: '0, b: '0, sum: '0, ovf: 1'b0, unf: 1'b0, tmo: 1'b0, lat: 0, acc_cyc: 0};
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST_N) begin
                if (in_flight) aborted++;
                in_flight  = 0;
                st_due     = 0;
                b_due      = 0;
                prev_valid = 0;
                prev_stall = 0;
            end else begin
                check_eq("st", 32'(St), 32'(st_due));
                if (st_due) check_eq("fpin_a", 32'(FPinput), 32'(cur.a));
                if (b_due)  check_eq("fpin_b", 32'(FPinput), 32'(cur.b));
                b_due  = st_due;
                st_due = 0;
                check_eq("busy", 32'(busy), 32'(in_flight));
                check_eq("op_ready", 32'(op_ready), 32'((!in_flight) || (res_valid && res_ready)));
                if (prev_stall) begin
                    check_eq("hold_valid", 32'(res_valid), 32'd1);
                    check_eq("hold_sum", 32'(res_sum), 32'(prev_sum));
                    check_eq("hold_flags", 32'({res_ovf, res_unf, res_tmo}), 32'(prev_flags));
                end
                if (res_valid && !prev_valid) begin
                    check_eq("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat + 4));
                    check_eq("res_sum", 32'(res_sum), 32'(cur.sum));
                    check_eq("res_flags", 32'({res_ovf, res_unf, res_tmo}),
                             32'({cur.ovf, cur.unf, cur.tmo}));
                end
                prev_stall = res_valid && !res_ready;
                prev_valid = res_valid;
                prev_sum   = res_sum;
                prev_flags = {res_ovf, res_unf, res_tmo};
                if (res_valid && res_ready) begin
                    results++;
                    last_sum = res_sum;
                    last_tmo = res_tmo;
                    if (op_valid && op_ready) b2b++;
                    else in_flight = 0;
                end
                if (op_valid && op_ready) begin
                    cur.a       = op_a;
                    cur.b       = op_b;
                    cur.sum     = nx_sum;
                    cur.tmo     = nx_tmo;
                    cur.ovf     = nx_tmo ? 1'b0 : nx_ovf;
                    cur.unf     = nx_tmo ? 1'b0 : nx_unf;
                    cur.lat     = nx_lat_exp;
                    cur.acc_cyc = cyc;
                    in_flight   = 1;
                    st_due      = 1;
                    accepted++;
                    adder_q.push_back('{lat: nx_lat_ad, ovf: nx_ovf, unf: nx_unf});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic send_op(input int a, input int b, input int lat,
                           input bit f_ovf, input bit f_unf, input bit f_tmo);
        int start;
        bit got;
        nx_sum     = f_tmo ? 16'h7E00 : int_to_half(a + b);
        nx_ovf     = f_ovf;
        nx_unf     = f_unf;
        nx_tmo     = f_tmo;
        nx_lat_ad  = lat;
        nx_lat_exp = f_tmo ? (TMO - 1) : lat;
        op_a       = int_to_half(a);
        op_b       = int_to_half(b);
        op_valid   = 1'b1;
        start      = accepted;
        got        = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK);
            if (accepted != start) begin
                got = 1;
                break;
            end
        end
        #1;
        op_valid = 1'b0;
        check_eq("op_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_result();
        bit got;
        got = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK);
            if (results + aborted == accepted) begin
                got = 1;
                break;
            end
        end
        #1;
        check_eq("result_seen", 32'(got), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_st"},    32'(St), 32'd0);
        check_eq({tag, "_fpin"},  32'(FPinput), 32'd0);
        check_eq({tag, "_valid"}, 32'(res_valid), 32'd0);
        check_eq({tag, "_sum"},   32'(res_sum), 32'd0);
        check_eq({tag, "_flags"}, 32'({res_ovf, res_unf, res_tmo}), 32'd0);
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int  ra;
        int  rb;
        bit  got;
        RST_N    = 1'b0;
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        nx_sum   = '0;
        nx_ovf   = 1'b0;
        nx_unf   = 1'b0;
        nx_tmo   = 1'b0;
        nx_lat_ad  = 1;
        nx_lat_exp = 1;
        repeat (5) @(posedge CLK);
        #1;
        check_reset_outputs("rst");
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // T1: 1 + 1
        rr_mode = 0;
        send_op(1, 1, 6, 1'b0, 1'b0, 1'b0);
        wait_result();
        check_eq("t1_sum", 32'(last_sum), 32'h4000);

        // T2: 2 + -2, result is zero
        send_op(2, -2, 9, 1'b0, 1'b0, 1'b0);
        wait_result();
        check_eq("t2_expfrac", 32'(last_sum[14:0]), 32'd0);

        // T3: result stalled 20 cycles; op_valid offered then withdrawn
        rr_mode = 2;
        send_op(100, -37, 5, 1'b1, 1'b0, 1'b0);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            if (res_valid) begin
                got = 1;
                break;
            end
        end
        #1;
        check_eq("t3_valid_seen", 32'(got), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (i == 4) begin
                op_a     = int_to_half(7);
                op_b     = int_to_half(8);
                op_valid = 1'b1;
            end
            if (i == 8) op_valid = 1'b0;
            @(posedge CLK);
            #1;
        end
        check_eq("t3_valid_held", 32'(res_valid), 32'd1);
        check_eq("t3_sum_held", 32'(res_sum), 32'(int_to_half(63)));
        rr_mode = 0;
        wait_result();

        // T4: back-to-back pair
        send_op(300, 400, 10, 1'b0, 1'b1, 1'b0);
        send_op(-5, -6, 3, 1'b1, 1'b1, 1'b0);
        wait_result();
        check_eq("t4_b2b", 32'(b2b != 0), 32'd1);
        check_eq("t4_sum", 32'(last_sum), 32'(int_to_half(-11)));

        // Randomized traffic with random consumer stalls
        rr_mode = 1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
            ra = int'($urandom_range(0, 2000)) - 1000;
            rb = int'($urandom_range(0, 2000)) - 1000;
            send_op(ra, rb, int'($urandom_range(1, 50)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        rr_mode = 0;
        wait_result();

        // T5: reset during WAIT for 64 cycles, then a fresh 1 + 1
        send_op(1, 1, 40, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        repeat (64) @(posedge CLK);
        #1;
        check_reset_outputs("t5_rst");
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("t5_no_stale", 32'(res_valid), 32'd0);
        send_op(1, 1, 8, 1'b0, 1'b0, 1'b0);
        wait_result();
        check_eq("t5_sum", 32'(last_sum), 32'h4000);

`ifdef FPDRV_TIMEOUT_EN
        // T6: adder too slow, watchdog returns a NaN abort; the late done is ignored
        send_op(3, 4, 90, 1'b1, 1'b1, 1'b1);
        wait_result();
        check_eq("t6_tmo", 32'(last_tmo), 32'd1);
        check_eq("t6_sum", 32'(last_sum), 32'h7E00);
        repeat (60) @(posedge CLK);
        #1;
        check_eq("t6_late_done", 32'(res_valid), 32'd0);
        send_op(10, 20, 4, 1'b0, 1'b0, 1'b0);
        wait_result();
        check_eq("t6_after_tmo", 32'(last_tmo), 32'd0);
`else
        // Without the watchdog a slow adder is simply waited for
        send_op(5, -7, 100, 1'b0, 1'b1, 1'b0);
        wait_result();
        check_eq("slow_sum", 32'(last_sum), 32'(int_to_half(-2)));
        check_eq("slow_tmo", 32'(last_tmo), 32'd0);
`endif

        repeat (4) @(posedge CLK);
        #1;
        check_eq("op_count", 32'(results), 32'(accepted - aborted));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
